// File: rtl/axilite_pkg.sv
// Shared types for the AXI-lite register bank: response codes, FSM state enums
// and an index-width helper used by the address decoder and the top.
package axilite_pkg;

    typedef logic [1:0] resp_t;

    localparam resp_t RESP_OKAY   = 2'd0;
    localparam resp_t RESP_EXOKAY = 2'd1;
    localparam resp_t RESP_SLVERR = 2'd2;
    localparam resp_t RESP_DECERR = 2'd3;

    typedef enum logic {W_IDLE, W_RESP} wr_state_t;
    typedef enum logic {R_IDLE, R_DATA} rd_state_t;

    // Width of a register index; a single-register bank still needs one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/axilite_addr_dec.sv
// Byte address to word-index decoder; flags indices beyond the register bank.
module axilite_addr_dec
    import axilite_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REGS   = 16,
    localparam int IDX_W     = idx_width(NUM_REGS)
) (
    input  logic [ADDR_WIDTH-1:0] addr_i,
    output logic [IDX_W-1:0]      idx_o,
    output logic                  dec_err_o
);

    localparam int OFF_W  = $clog2(DATA_WIDTH / 8);
    localparam int WORD_W = ADDR_WIDTH - OFF_W;

    logic [WORD_W-1:0] word;
    logic              unused_offset;

    assign word      = addr_i[ADDR_WIDTH-1:OFF_W];
    assign idx_o     = word[IDX_W-1:0];
    // One extra bit so NUM_REGS itself is representable in the comparison.
    assign dec_err_o = {1'b0, word} >= (WORD_W + 1)'(NUM_REGS);

    assign unused_offset = ^addr_i[OFF_W-1:0];

endmodule

// File: rtl/axilite_regbank.sv
// AXI-lite slave register bank with independent write and read FSMs.
// Define AXILITE_REGBANK_STATUS_EN to make indices >= NUM_RW read-only status words.
module axilite_regbank
    import axilite_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REGS   = 16
`ifdef AXILITE_REGBANK_STATUS_EN
    ,
    parameter int NUM_RW     = NUM_REGS / 2
`endif
) (
    input  logic                           aclk,
    input  logic                           areset,
    input  logic [ADDR_WIDTH-1:0]          awaddr,
    input  logic                           awvalid,
    output logic                           awready,
    input  logic [DATA_WIDTH-1:0]          wdata,
    input  logic [DATA_WIDTH/8-1:0]        wstrb,
    input  logic                           wvalid,
    output logic                           wready,
    output logic [1:0]                     bresp,
    output logic                           bvalid,
    input  logic                           bready,
    input  logic [ADDR_WIDTH-1:0]          araddr,
    input  logic                           arvalid,
    output logic                           arready,
    output logic [DATA_WIDTH-1:0]          rdata,
    output logic [1:0]                     rresp,
    output logic                           rvalid,
    input  logic                           rready,
`ifdef AXILITE_REGBANK_STATUS_EN
    input  logic [(NUM_REGS-NUM_RW)*DATA_WIDTH-1:0] status_in,
`endif
    output logic [NUM_REGS*DATA_WIDTH-1:0] reg_q,
    output logic [NUM_REGS-1:0]            wr_pulse
);

    localparam int STRB_W = DATA_WIDTH / 8;
    localparam int IDX_W  = idx_width(NUM_REGS);

    logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];

    wr_state_t             wr_state_q;
    logic                  aw_held_q, w_held_q, aw_err_q;
    logic [IDX_W-1:0]      aw_idx_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [STRB_W-1:0]     wstrb_q;
    logic                  bvalid_q;
    resp_t                 bresp_q;
    logic [NUM_REGS-1:0]   wr_pulse_q;

    rd_state_t             rd_state_q;
    logic                  rvalid_q;
    resp_t                 rresp_q;
    logic [DATA_WIDTH-1:0] rdata_q;

    logic [IDX_W-1:0]      aw_dec_idx, ar_dec_idx;
    logic                  aw_dec_err, ar_dec_err;
    logic                  aw_hs, w_hs, ar_hs, commit;

    logic [IDX_W-1:0]      wr_idx_d;
    logic                  wr_err_d, wr_ro_d;
    logic [DATA_WIDTH-1:0] wr_data_d, rd_data_d;
    logic [STRB_W-1:0]     wr_strb_d;
    resp_t                 wr_resp_d, rd_resp_d;

    axilite_addr_dec #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH),
        .NUM_REGS   (NUM_REGS)
    ) u_aw_dec (
        .addr_i    (awaddr),
        .idx_o     (aw_dec_idx),
        .dec_err_o (aw_dec_err)
    );

    axilite_addr_dec #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH),
        .NUM_REGS   (NUM_REGS)
    ) u_ar_dec (
        .addr_i    (araddr),
        .idx_o     (ar_dec_idx),
        .dec_err_o (ar_dec_err)
    );

    // NOTE: outputs are masked by areset so the bus sees an idle slave during reset.
    assign awready  = !areset && (wr_state_q == W_IDLE) && !aw_held_q;
    assign wready   = !areset && (wr_state_q == W_IDLE) && !w_held_q;
    assign arready  = !areset && (rd_state_q == R_IDLE);
    assign bvalid   = !areset && bvalid_q;
    assign bresp    = areset ? RESP_OKAY : bresp_q;
    assign rvalid   = !areset && rvalid_q;
    assign rresp    = areset ? RESP_OKAY : rresp_q;
    assign rdata    = areset ? '0 : rdata_q;
    assign wr_pulse = areset ? '0 : wr_pulse_q;

    assign aw_hs  = awvalid && awready;
    assign w_hs   = wvalid && wready;
    assign ar_hs  = arvalid && arready;
    assign commit = (aw_held_q || aw_hs) && (w_held_q || w_hs);

    // A channel already held takes priority over the live bus for the commit.
    assign wr_idx_d  = aw_held_q ? aw_idx_q : aw_dec_idx;
    assign wr_err_d  = aw_held_q ? aw_err_q : aw_dec_err;
    assign wr_data_d = w_held_q  ? wdata_q  : wdata;
    assign wr_strb_d = w_held_q  ? wstrb_q  : wstrb;

`ifdef AXILITE_REGBANK_STATUS_EN
    localparam int ST_N = NUM_REGS - NUM_RW;
    localparam int ST_W = idx_width(ST_N);

    logic [DATA_WIDTH-1:0] status_w [ST_N];
    logic [IDX_W-1:0]      st_off;

    for (genvar j = 0; j < ST_N; j++) begin : g_status
        assign status_w[j] = status_in[j*DATA_WIDTH +: DATA_WIDTH];
    end

    assign wr_ro_d = 32'(wr_idx_d) >= NUM_RW;
    assign st_off  = ar_dec_idx - IDX_W'(NUM_RW);
`else
    assign wr_ro_d = 1'b0;
`endif

    always_comb begin
        wr_resp_d = RESP_OKAY;
        if (wr_err_d)     wr_resp_d = RESP_DECERR;
        else if (wr_ro_d) wr_resp_d = RESP_SLVERR;
    end

    always_comb begin
        rd_resp_d = RESP_OKAY;
        rd_data_d = '0;
        if (ar_dec_err) rd_resp_d = RESP_DECERR;
`ifdef AXILITE_REGBANK_STATUS_EN
        else if (32'(ar_dec_idx) >= NUM_RW) rd_data_d = status_w[st_off[ST_W-1:0]];
`endif
        else rd_data_d = regs_q[ar_dec_idx];
    end

    // NOTE: regs_q is a flop array, not a RAM, so it is cleared by reset like any other state.
    always_ff @(posedge aclk) begin
        if (areset) begin
            wr_state_q <= W_IDLE;
            aw_held_q  <= 1'b0;
            w_held_q   <= 1'b0;
            aw_err_q   <= 1'b0;
            aw_idx_q   <= '0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            bvalid_q   <= 1'b0;
            bresp_q    <= RESP_OKAY;
            wr_pulse_q <= '0;
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
        end else begin
            wr_pulse_q <= '0;
            case (wr_state_q)
                W_IDLE: begin
                    if (commit) begin
                        aw_held_q  <= 1'b0;
                        w_held_q   <= 1'b0;
                        bvalid_q   <= 1'b1;
                        bresp_q    <= wr_resp_d;
                        wr_state_q <= W_RESP;
                        if (wr_resp_d == RESP_OKAY) begin
                            wr_pulse_q[wr_idx_d] <= 1'b1;
                            for (int k = 0; k < STRB_W; k++) begin
                                if (wr_strb_d[k]) regs_q[wr_idx_d][k*8 +: 8] <= wr_data_d[k*8 +: 8];
                            end
                        end
                    end else begin
                        if (aw_hs) begin
                            aw_held_q <= 1'b1;
                            aw_idx_q  <= aw_dec_idx;
                            aw_err_q  <= aw_dec_err;
                        end
                        if (w_hs) begin
                            w_held_q <= 1'b1;
                            wdata_q  <= wdata;
                            wstrb_q  <= wstrb;
                        end
                    end
                end
                W_RESP: begin
                    if (bready) begin
                        bvalid_q   <= 1'b0;
                        bresp_q    <= RESP_OKAY;
                        wr_state_q <= W_IDLE;
                    end
                end
                default: wr_state_q <= W_IDLE;
            endcase
        end
    end

    // Reads sample regs_q before this edge's write lands, giving pre-write data.
    always_ff @(posedge aclk) begin
        if (areset) begin
            rd_state_q <= R_IDLE;
            rvalid_q   <= 1'b0;
            rresp_q    <= RESP_OKAY;
            rdata_q    <= '0;
        end else begin
            case (rd_state_q)
                R_IDLE: begin
                    if (ar_hs) begin
                        rvalid_q   <= 1'b1;
                        rresp_q    <= rd_resp_d;
                        rdata_q    <= rd_data_d;
                        rd_state_q <= R_DATA;
                    end
                end
                R_DATA: begin
                    if (rready) begin
                        rvalid_q   <= 1'b0;
                        rresp_q    <= RESP_OKAY;
                        rdata_q    <= '0;
                        rd_state_q <= R_IDLE;
                    end
                end
                default: rd_state_q <= R_IDLE;
            endcase
        end
    end

    for (genvar i = 0; i < NUM_REGS; i++) begin : g_flat
        assign reg_q[i*DATA_WIDTH +: DATA_WIDTH] = regs_q[i];
    end

endmodule
